// File: rtl/motor_cmd_pkg.sv
// Shared types and helpers for the motor command ramp stage: mode/drive encodings,
// channel FSM states and the write-time speed clamp.
package motor_cmd_pkg;

  localparam int unsigned SpeedW         = 14;
  localparam int unsigned RawSpeedW      = 13;
  localparam int unsigned DutyW          = 12;
  localparam int unsigned DutyMaxDefault = 2600;

  typedef logic signed [SpeedW-1:0] speed_t;
  typedef logic [DutyW-1:0]         duty_t;

  typedef enum logic [1:0] {
    ModeIdle    = 2'b00,
    ModeRun     = 2'b01,
    ModeBrake   = 2'b10,
    ModeIdleAlt = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    DrvIdle  = 2'b00,
    DrvRev   = 2'b01,
    DrvFwd   = 2'b10,
    DrvBrake = 2'b11
  } drive_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDead,
    StBrake
  } chan_state_e;

  function automatic logic is_pos(speed_t s);
    return !s[SpeedW-1] && (s != '0);
  endfunction

  // Sign-extend the 13-bit host speed and clamp it to +/-lim.
  function automatic speed_t clamp_speed(logic [RawSpeedW-1:0] raw, speed_t lim);
    speed_t s;
    s = speed_t'($signed(raw));
    if (s > lim) begin
      s = lim;
    end else if (s < -lim) begin
      s = -lim;
    end
    return s;
  endfunction

endpackage

// File: rtl/motor_cmd_ramp_if.sv
// Host command / driver output bundle of the motor command ramp stage.
interface motor_cmd_ramp_if;
  import motor_cmd_pkg::*;

  logic        enable;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  duty_t       ramp_step;
  duty_t       duty0;
  duty_t       duty1;
  duty_t       duty2;
  duty_t       duty3;
  logic [7:0]  drive_code;
  logic        mot_en;
  logic        wdog_trip;

  modport master (
    output enable, wr_en, wr_addr, wr_data, ramp_step,
    input  duty0, duty1, duty2, duty3, drive_code, mot_en, wdog_trip
  );

  modport slave (
    input  enable, wr_en, wr_addr, wr_data, ramp_step,
    output duty0, duty1, duty2, duty3, drive_code, mot_en, wdog_trip
  );

endinterface

// File: rtl/motor_ramp_chan.sv
// One motor channel: slew-limited speed ramp with dead-time on direction reversal.
// Outputs are registered from the next-state values.
module motor_ramp_chan
  import motor_cmd_pkg::*;
#(
  parameter int unsigned DUTY_MAX   = DutyMaxDefault,
  parameter int unsigned DEAD_TICKS = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   tick_i,
  input  logic   wr_i,
  input  mode_e  mode_i,
  input  speed_t speed_i,
  input  duty_t  ramp_step_i,
  input  logic   force_idle_i,
  output duty_t  duty_o,
  output drive_e code_o
);

  localparam int unsigned DeadW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;

  chan_state_e      state_q, state_d;
  speed_t           target_q, target_d;
  speed_t           cur_q, cur_d;
  logic [DeadW-1:0] dead_q, dead_d;
  duty_t            duty_q, duty_d;
  drive_e           code_q, code_d;

  speed_t diff, step_s, stepped, mag;
  logic   reversal;

  always_comb begin
    diff   = target_q - cur_q;
    step_s = $signed({2'b00, ramp_step_i});
    if (ramp_step_i == '0) begin
      stepped = target_q;
    end else if (!diff[SpeedW-1] && (diff <= step_s)) begin
      stepped = target_q;
    end else if (diff[SpeedW-1] && (-diff <= step_s)) begin
      stepped = target_q;
    end else if (!diff[SpeedW-1]) begin
      stepped = cur_q + step_s;
    end else begin
      stepped = cur_q - step_s;
    end
    // A step stops at zero rather than passing through it.
    if ((cur_q[SpeedW-1] && is_pos(stepped)) || (is_pos(cur_q) && stepped[SpeedW-1])) begin
      stepped = '0;
    end
    reversal = (cur_q != '0) && (stepped == '0) &&
               ((is_pos(cur_q) && target_q[SpeedW-1]) || (cur_q[SpeedW-1] && is_pos(target_q)));
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cur_d    = cur_q;
    dead_d   = dead_q;

    unique case (state_q)
      StRun: begin
        if (tick_i) begin
          cur_d = stepped;
          if (reversal && (DEAD_TICKS != 0)) begin
            state_d = StDead;
            dead_d  = '0;
          end
        end
      end
      StDead: begin
        if (tick_i) begin
          if (dead_q == DeadW'(DEAD_TICKS - 1)) begin
            state_d = StRun;
          end else begin
            dead_d = dead_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Writes take effect after the tick step, so a coincident step uses the old target.
    if (wr_i) begin
      unique case (mode_i)
        ModeRun: begin
          target_d = speed_i;
          if ((state_q == StIdle) || (state_q == StBrake)) begin
            state_d = StRun;
            cur_d   = '0;
          end
        end
        ModeBrake: begin
          state_d = StBrake;
          cur_d   = '0;
        end
        default: begin
          state_d = StIdle;
          cur_d   = '0;
        end
      endcase
    end

    if (force_idle_i) begin
      state_d = StIdle;
      cur_d   = '0;
    end
  end

  always_comb begin
    mag    = cur_d[SpeedW-1] ? -cur_d : cur_d;
    duty_d = '0;
    code_d = DrvIdle;
    unique case (state_d)
      StRun: begin
        duty_d = duty_t'(mag);
        if (is_pos(cur_d)) begin
          code_d = DrvFwd;
        end else if (cur_d[SpeedW-1]) begin
          code_d = DrvRev;
        end
      end
      StBrake: begin
        duty_d = duty_t'(DUTY_MAX);
        code_d = DrvBrake;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      target_q <= '0;
      cur_q    <= '0;
      dead_q   <= '0;
      duty_q   <= '0;
      code_q   <= DrvIdle;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cur_q    <= cur_d;
      dead_q   <= dead_d;
      duty_q   <= duty_d;
      code_q   <= code_d;
    end
  end

  assign duty_o = duty_q;
  assign code_o = code_q;

endmodule

// File: rtl/motor_cmd_ramp.sv
// Command stage for the 4-channel PWM motor driver: tick divider, command watchdog,
// write decode/clamp and output packing around four ramp channels.
module motor_cmd_ramp
  import motor_cmd_pkg::*;
#(
  parameter int unsigned DUTY_MAX   = DutyMaxDefault,
  parameter int unsigned RAMP_DIV   = 2601,
  parameter int unsigned DEAD_TICKS = 4,
  parameter int unsigned WDOG_TICKS = 1000
) (
  input logic             clk,
  input logic             rst_n,
  motor_cmd_ramp_if.slave bus
);

  localparam int unsigned DivW     = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned WdW      = (WDOG_TICKS > 1) ? $clog2(WDOG_TICKS) : 1;
  localparam speed_t      SpeedLim = speed_t'(DUTY_MAX);

  logic [DivW-1:0] div_q, div_d;
  logic [WdW-1:0]  wdog_q, wdog_d;
  logic            trip_q, trip_d;
  logic            mot_en_q, mot_en_d;
  logic            tick;
  mode_e           wr_mode;
  speed_t          wr_speed;
  duty_t           duty [4];
  drive_e          code [4];
  logic            unused_reserved;

  assign tick            = (div_q == DivW'(RAMP_DIV - 1));
  assign wr_mode         = mode_e'(bus.wr_data[15:14]);
  assign wr_speed        = clamp_speed(bus.wr_data[12:0], SpeedLim);
  assign unused_reserved = bus.wr_data[13];

  always_comb begin
    div_d  = tick ? '0 : div_q + 1'b1;
    wdog_d = wdog_q;
    trip_d = trip_q;
    if (bus.wr_en) begin
      wdog_d = '0;
      trip_d = 1'b0;
    end else if ((WDOG_TICKS != 0) && tick && !trip_q) begin
      if (wdog_q == WdW'(WDOG_TICKS - 1)) begin
        trip_d = 1'b1;
        wdog_d = '0;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
    mot_en_d = bus.enable & ~trip_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      wdog_q   <= '0;
      trip_q   <= 1'b0;
      mot_en_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      wdog_q   <= wdog_d;
      trip_q   <= trip_d;
      mot_en_q <= mot_en_d;
    end
  end

  // trip_d is never set in a write cycle, so a write that clears the trip applies normally.
  for (genvar i = 0; i < 4; i++) begin : g_chan
    motor_ramp_chan #(
      .DUTY_MAX  (DUTY_MAX),
      .DEAD_TICKS(DEAD_TICKS)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick_i      (tick),
      .wr_i        (bus.wr_en && (bus.wr_addr == 2'(i))),
      .mode_i      (wr_mode),
      .speed_i     (wr_speed),
      .ramp_step_i (bus.ramp_step),
      .force_idle_i(trip_d),
      .duty_o      (duty[i]),
      .code_o      (code[i])
    );
  end

  assign bus.duty0      = duty[0];
  assign bus.duty1      = duty[1];
  assign bus.duty2      = duty[2];
  assign bus.duty3      = duty[3];
  assign bus.drive_code = {code[0], code[1], code[2], code[3]};
  assign bus.mot_en     = mot_en_q;
  assign bus.wdog_trip  = trip_q;

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Bench for motor_cmd_ramp: directed scenarios plus random writes, every cycle compared
// against a tick-level behavioural model of the four channels and the watchdog.
module tb_motor_cmd_ramp;

  localparam int RampDiv   = 4;
  localparam int DeadTicks = 2;
  localparam int WdogTicks = 20;
  localparam int DutyMax   = 2600;
  localparam int MIdle = 0, MRun = 1, MDead = 2, MBrake = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  motor_cmd_ramp_if bus ();

  motor_cmd_ramp #(
    .DUTY_MAX  (DutyMax),
    .RAMP_DIV  (RampDiv),
    .DEAD_TICKS(DeadTicks),
    .WDOG_TICKS(WdogTicks)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int m_st [4];
  int m_cur [4];
  int m_tgt [4];
  int m_dead [4];
  int m_div, m_wcnt;
  bit m_trip, m_en, m_tick;

  int t1d [4] = '{30, 60, 90, 100};
  int t2d [6] = '{30, 0, 0, 0, 30, 60};
  int t2c [6] = '{2, 0, 0, 0, 1, 1};

  function automatic int sgn(int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_st[c] = MIdle; m_cur[c] = 0; m_tgt[c] = 0; m_dead[c] = 0;
    end
    m_div = 0; m_wcnt = 0; m_trip = 0; m_en = 0; m_tick = 0;
  endtask

  // One clock of the reference: tick step, then host write, then watchdog override.
  task automatic model_clock();
    int nxt, d, spd, step;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_tick = (m_div == RampDiv - 1);
      m_div  = m_tick ? 0 : m_div + 1;
      step   = int'(bus.ramp_step);
      for (int c = 0; c < 4; c++) begin
        if (m_tick && m_st[c] == MRun) begin
          d = m_tgt[c] - m_cur[c];
          if (step == 0 || iabs(d) <= step) nxt = m_tgt[c];
          else nxt = m_cur[c] + sgn(d) * step;
          if (nxt != 0 && sgn(nxt) == -sgn(m_cur[c])) nxt = 0;
          if (m_cur[c] != 0 && nxt == 0 && sgn(m_tgt[c]) == -sgn(m_cur[c]) && DeadTicks > 0) begin
            m_st[c]   = MDead;
            m_dead[c] = DeadTicks;
          end
          m_cur[c] = nxt;
        end else if (m_tick && m_st[c] == MDead) begin
          m_dead[c]--;
          if (m_dead[c] == 0) m_st[c] = MRun;
        end
        if (bus.wr_en && int'(bus.wr_addr) == c) begin
          case (bus.wr_data[15:14])
            2'b01: begin
              spd = int'(bus.wr_data[12:0]);
              if (spd >= 4096) spd -= 8192;
              if (spd > DutyMax) spd = DutyMax;
              if (spd < -DutyMax) spd = -DutyMax;
              m_tgt[c] = spd;
              if (m_st[c] == MIdle || m_st[c] == MBrake) begin
                m_st[c] = MRun; m_cur[c] = 0;
              end
            end
            2'b10:   begin m_st[c] = MBrake; m_cur[c] = 0; end
            default: begin m_st[c] = MIdle;  m_cur[c] = 0; end
          endcase
        end
      end
      if (bus.wr_en) begin
        m_wcnt = 0; m_trip = 0;
      end else if (m_tick && !m_trip) begin
        m_wcnt++;
        if (m_wcnt == WdogTicks) m_trip = 1;
      end
      if (m_trip) begin
        for (int c = 0; c < 4; c++) begin m_st[c] = MIdle; m_cur[c] = 0; end
      end
      m_en = bus.enable && !m_trip;
    end
  endtask

  function automatic int exp_duty(int c);
    if (m_st[c] == MRun) return iabs(m_cur[c]);
    if (m_st[c] == MBrake) return DutyMax;
    return 0;
  endfunction

  function automatic int exp_code(int c);
    if (m_st[c] == MRun) return (m_cur[c] > 0) ? 2 : ((m_cur[c] < 0) ? 1 : 0);
    if (m_st[c] == MBrake) return 3;
    return 0;
  endfunction

  task automatic check_outputs();
    int code;
    code = 0;
    for (int c = 0; c < 4; c++) code = (code << 2) | exp_code(c);
    chk("duty0", int'(bus.duty0), exp_duty(0));
    chk("duty1", int'(bus.duty1), exp_duty(1));
    chk("duty2", int'(bus.duty2), exp_duty(2));
    chk("duty3", int'(bus.duty3), exp_duty(3));
    chk("drive_code", int'(bus.drive_code), code);
    chk("mot_en", int'(bus.mot_en), int'(m_en));
    chk("wdog_trip", int'(bus.wdog_trip), int'(m_trip));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_clock();
    #1;
    check_outputs();
  endtask

  task automatic write(input int ch, input int mode, input int spd);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'(ch);
    bus.wr_data = {2'(mode), 1'($urandom_range(1)), 13'(spd)};
    cyc();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!m_tick && n < 2 * RampDiv);
  endtask

  task automatic ticks(input int n);
    repeat (n) wait_tick();
  endtask

  initial begin
    int mx;
    bus.enable    = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.ramp_step = 12'd30;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_outputs();
    chk("reset_code", int'(bus.drive_code), 0);
    @(negedge clk) rst_n = 1'b1;

    // Ramp up from idle
    write(0, 1, 100);
    for (int k = 0; k < 4; k++) begin
      wait_tick();
      chk("t1_duty0", int'(bus.duty0), t1d[k]);
    end
    chk("t1_code0", int'(bus.drive_code[7:6]), 2);
    chk("t1_mot_en", int'(bus.mot_en), 1);

    // Reversal with dead-time
    write(1, 1, 60);
    ticks(2);
    chk("t2_pre", int'(bus.duty1), 60);
    write(1, 1, -60);
    for (int k = 0; k < 6; k++) begin
      wait_tick();
      chk("t2_duty1", int'(bus.duty1), t2d[k]);
      chk("t2_code1", int'(bus.drive_code[5:4]), t2c[k]);
    end

    // Over-range speed clamps
    bus.ramp_step = 12'd1000;
    write(2, 1, 4000);
    mx = 0;
    repeat (4) begin
      wait_tick();
      if (int'(bus.duty2) > mx) mx = int'(bus.duty2);
    end
    chk("t3_final", int'(bus.duty2), 2600);
    chk("t3_peak", mx, 2600);

    // Brake mid-ramp, then idle
    bus.ramp_step = 12'd100;
    write(3, 1, 500);
    ticks(2);
    chk("t4_ramp", int'(bus.duty3), 200);
    write(3, 2, 0);
    chk("t4_brake_duty", int'(bus.duty3), 2600);
    chk("t4_brake_code", int'(bus.drive_code[1:0]), 3);
    cyc();
    write(3, 0, 0);
    chk("t4_idle_duty", int'(bus.duty3), 0);
    chk("t4_idle_code", int'(bus.drive_code[1:0]), 0);

    // Watchdog
    ticks(WdogTicks - 1);
    chk("t5_pre_trip", int'(bus.wdog_trip), 0);
    wait_tick();
    chk("t5_trip", int'(bus.wdog_trip), 1);
    chk("t5_code", int'(bus.drive_code), 0);
    chk("t5_duty0", int'(bus.duty0), 0);
    chk("t5_duty2", int'(bus.duty2), 0);
    chk("t5_mot_en", int'(bus.mot_en), 0);
    write(1, 1, 200);
    chk("t5_clear", int'(bus.wdog_trip), 0);
    chk("t5_mot_en_back", int'(bus.mot_en), 1);

    // Random traffic against the model
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(15) == 0)
        bus.ramp_step = ($urandom_range(3) == 0) ? 12'd0 : 12'($urandom_range(800));
      if ($urandom_range(31) == 0) bus.enable = 1'($urandom_range(1));
      if ($urandom_range(3) == 0)
        write(int'($urandom_range(3)), ($urandom_range(7) < 6) ? 1 : int'($urandom_range(3)),
              int'($urandom_range(8191)) - 4096);
      else
        cyc();
    end
    repeat (100) cyc();

    // Asynchronous reset mid-ramp
    bus.enable    = 1'b1;
    bus.ramp_step = 12'd100;
    write(0, 1, 2000);
    ticks(3);
    chk("t6_ramp", int'(bus.duty0), 300);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_duty0", int'(bus.duty0), 0);
    chk("t6_code", int'(bus.drive_code), 0);
    chk("t6_mot_en", int'(bus.mot_en), 0);
    model_reset();
    repeat (2) cyc();
    @(negedge clk) rst_n = 1'b1;
    repeat (12) cyc();
    chk("t6_no_drive", int'(bus.drive_code), 0);
    chk("t6_no_duty", int'(bus.duty0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
